// File: rtl/trng_pkg.sv
// Shared types and default parameter values for the TRNG collector.
package trng_pkg;

   localparam int WIDTH_DEF      = 32;
   localparam int VN_EN_DEF      = 1;
   localparam int RCT_CUTOFF_DEF = 32;

   // Run counter wide enough for the largest legal cutoff.
   localparam int RUN_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      WARMUP,
      COLLECT,
      FULL,
      FAIL
   } state_t;

endpackage

// File: rtl/trng_vn_extractor.sv
// Von Neumann debiaser: pairs raw samples, emits the first bit of each unequal pair.
module trng_vn_extractor (
   input  logic clk,
   input  logic reset,
   input  logic sample_valid,
   input  logic raw_bit,
   input  logic flush,
   output logic bit_valid,
   output logic bit_out
);

   logic have_first;
   logic first;

   always_ff @(posedge clk) begin
      if (reset) begin
         have_first <= 1'b0;
         first      <= 1'b0;
      end else if (flush) begin
         have_first <= 1'b0;
         first      <= 1'b0;
      end else if (sample_valid) begin
         if (have_first) begin
            have_first <= 1'b0;
            first      <= 1'b0;
         end else begin
            have_first <= 1'b1;
            first      <= raw_bit;
         end
      end
   end

   // 01 yields 0 and 10 yields 1, so the emitted bit is always the first of the pair.
   assign bit_valid = sample_valid && !flush && have_first && (first != raw_bit);
   assign bit_out   = first;

endmodule

// File: rtl/trng_collector.sv
// Collects debiased TRNG bits into WIDTH-bit words with a repetition-count health test.
module trng_collector
   import trng_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int VN_EN      = VN_EN_DEF,
   parameter int RCT_CUTOFF = RCT_CUTOFF_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic             trng_en,
   input  logic             trng_bit,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   input  logic             ready,
   output logic             health_fail,
   input  logic             clear_fail
);

   localparam int                CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [RUN_W-1:0]  CUTOFF   = RCT_CUTOFF[RUN_W-1:0];

   state_t             state;
   state_t             state_next;
   logic [WIDTH-1:0]   shreg;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_next;
   logic [RUN_W-1:0]   run;
   logic [RUN_W-1:0]   run_next;
   logic               last_bit;

   logic               in_collect;
   logic               sampling;
   logic               acc_valid;
   logic               acc_bit;
   logic               trip;
   logic               word_done;
   logic               xfer;
   logic               shift_en;

   function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
      return (v == {RUN_W{1'b1}}) ? v : v + RUN_W'(1);
   endfunction

   assign in_collect = (state == COLLECT);
   assign sampling   = (state == COLLECT) || (state == FULL);

   generate
      if (VN_EN != 0) begin : g_vn
         trng_vn_extractor u_vn (
            .clk          (clk),
            .reset        (reset),
            .sample_valid (in_collect),
            .raw_bit      (trng_bit),
            .flush        (!in_collect),
            .bit_valid    (acc_valid),
            .bit_out      (acc_bit)
         );
      end else begin : g_raw
         assign acc_valid = in_collect;
         assign acc_bit   = trng_bit;
      end
   endgenerate

   // A zero run count means no previous sample since warmup.
   always_comb begin
      run_next = RUN_W'(1);
      if (run != '0 && trng_bit == last_bit) begin
         run_next = sat_inc(run);
      end
   end

   assign trip      = sampling && (run_next >= CUTOFF);
   assign word_done = acc_valid && (cnt == LAST_CNT);
   assign xfer      = (state == FULL) && ready;

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (enable) state_next = WARMUP;
         end
         WARMUP: begin
            state_next = enable ? COLLECT : IDLE;
         end
         COLLECT: begin
            if (trip)           state_next = FAIL;
            else if (!enable)   state_next = IDLE;
            else if (word_done) state_next = FULL;
         end
         FULL: begin
            if (trip)         state_next = FAIL;
            else if (!enable) state_next = IDLE;
            else if (ready)   state_next = COLLECT;
         end
         FAIL: begin
            if (clear_fail) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Bits only land in the word when the collection is actually continuing.
   assign shift_en = acc_valid && (state_next == COLLECT || state_next == FULL);

   always_comb begin
      cnt_next = cnt;
      if (state_next != COLLECT && state_next != FULL) begin
         cnt_next = '0;
      end else if (xfer) begin
         cnt_next = '0;
      end else if (shift_en) begin
         cnt_next = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         shreg    <= '0;
         cnt      <= '0;
         run      <= '0;
         last_bit <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (shift_en) begin
            shreg <= {shreg[WIDTH-2:0], acc_bit};
         end
         if (state == WARMUP) begin
            run <= '0;
         end else if (sampling) begin
            run      <= run_next;
            last_bit <= trng_bit;
         end
      end
   end

   assign trng_en     = (state == WARMUP) || (state == COLLECT) || (state == FULL);
   assign valid       = (state == FULL);
   assign health_fail = (state == FAIL);
   assign data        = shreg;

endmodule
